// File: rtl/dp_issue.sv
// Three-state issue stage for ARM data-processing instructions: latches a word and its
// register operands, drives an external ALU, then writes back and updates the NZCV flags.
module dp_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [3:0]  rn_addr,
  output logic [3:0]  rm_addr,
  input  logic [31:0] rn_data,
  input  logic [31:0] rm_data,
  output logic [3:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_carry_in,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_nzvc,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [3:0]  flags,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  // Rn is consumed at accept time through rn_data, so its field is not kept.
  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  cls;
    logic        imm;
    logic [3:0]  opcode;
    logic        s;
    logic [3:0]  rd;
    logic [11:0] op2;
  } dp_word_t;

  state_e      state_q;
  dp_word_t    ins_q;
  logic [31:0] rn_q, rm_q;
  logic [3:0]  nzvc_q;
  logic        shc_q, flag_upd_q;
  logic [3:0]  flags_q;
  logic        wb_en_q, illegal_q;
  logic [3:0]  wb_addr_q;
  logic [31:0] wb_data_q;

  logic [4:0]  rot, shamt;
  logic [31:0] imm_w, ror_w, op2_val;
  logic [32:0] shl_w;
  logic        shc;
  logic        f_n, f_z, f_c, f_v;
  logic        cond_ok, legal, is_test, is_arith;

  assign {f_n, f_z, f_c, f_v} = flags_q;

  always_comb begin
    rot   = {ins_q.op2[11:8], 1'b0};
    imm_w = {24'd0, ins_q.op2[7:0]};
    ror_w = 32'({imm_w, imm_w} >> rot);
    shamt = ins_q.op2[11:7];
    shl_w = {1'b0, rm_q} << shamt;
    if (ins_q.imm) begin
      op2_val = ror_w;
      shc     = (rot != '0) ? ror_w[31] : f_c;
    end else begin
      op2_val = shl_w[31:0];
      shc     = (shamt != '0) ? shl_w[32] : f_c;
    end
  end

  always_comb begin
    case (ins_q.cond)
      4'h0:    cond_ok = f_z;
      4'h1:    cond_ok = !f_z;
      4'h2:    cond_ok = f_c;
      4'h3:    cond_ok = !f_c;
      4'h4:    cond_ok = f_n;
      4'h5:    cond_ok = !f_n;
      4'h6:    cond_ok = f_v;
      4'h7:    cond_ok = !f_v;
      4'h8:    cond_ok = f_c && !f_z;
      4'h9:    cond_ok = !f_c || f_z;
      4'hA:    cond_ok = (f_n == f_v);
      4'hB:    cond_ok = (f_n != f_v);
      4'hC:    cond_ok = !f_z && (f_n == f_v);
      4'hD:    cond_ok = f_z || (f_n != f_v);
      4'hE:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // TST/TEQ/CMP/CMN only make sense with S set; without it they are illegal.
  always_comb begin
    is_test  = (ins_q.opcode[3:2] == 2'b10);
    is_arith = (ins_q.opcode inside {[4'b0010:4'b0111], 4'b1010, 4'b1011});
    legal    = (ins_q.cls == 2'b00)
            && (ins_q.imm || (!ins_q.op2[4] && ins_q.op2[6:5] == 2'b00))
            && !(is_test && !ins_q.s);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ins_q      <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      nzvc_q     <= '0;
      shc_q      <= 1'b0;
      flag_upd_q <= 1'b0;
      flags_q    <= '0;
      wb_en_q    <= 1'b0;
      illegal_q  <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            ins_q   <= {instr[31:20], instr[15:0]};
            rn_q    <= rn_data;
            rm_q    <= rm_data;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          nzvc_q     <= alu_nzvc;
          shc_q      <= shc;
          wb_data_q  <= alu_result;
          wb_addr_q  <= ins_q.rd;
          wb_en_q    <= cond_ok && legal && !is_test;
          illegal_q  <= !legal;
          flag_upd_q <= cond_ok && legal && ins_q.s;
          state_q    <= WB;
        end
        WB: begin
          wb_en_q   <= 1'b0;
          illegal_q <= 1'b0;
          if (flag_upd_q) begin
            if (is_arith) flags_q <= {nzvc_q[3], nzvc_q[2], nzvc_q[0], nzvc_q[1]};
            else          flags_q <= {nzvc_q[3], nzvc_q[2], shc_q, flags_q[0]};
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign rn_addr      = instr[19:16];
  assign rm_addr      = instr[3:0];
  assign alu_opcode   = ins_q.opcode;
  assign alu_a        = rn_q;
  assign alu_b        = op2_val;
  assign alu_carry_in = f_c;
  assign wb_en        = wb_en_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign flags        = flags_q;
  assign illegal      = illegal_q;

endmodule
